hilo_muldiv_seq: RTL and testbench

Multi-cycle sequencer for the MULT/MULTU/DIV/DIVU/MTHI/MTLO group of the single-cycle CPU. It owns the HI/LO registers and runs an iterative shift-add multiplier and restoring divider. While an operation runs it holds `stall` high, which freezes the PC register and suppresses writes to the register file.

---
 rtl/hilo_pkg.sv | 26 ++
 rtl/hilo_muldiv_seq_if.sv | 24 ++
 rtl/muldiv_iter_core.sv | 124 ++++++++++++
 rtl/hilo_muldiv_seq.sv | 132 +++++++++++++
 tb/tb_hilo_muldiv_seq.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM state encoding and the default datapath width.
package hilo_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Codes 000..011 are the iterative ops; bit 1 selects divide, bit 0 unsigned.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// Bundle between the CPU datapath (master) and the HI/LO sequencer (slave).
interface hilo_muldiv_seq_if #(
    parameter int WIDTH = hilo_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output stall, busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: shift-add multiplier and restoring divider on operand
// magnitudes, plus the final sign correction and divide-by-zero result.
module muldiv_iter_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] acc_reg;     // {partial product, remaining multiplier}
    logic [WIDTH-1:0]   opnd_reg;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quot_reg;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   a_raw_reg;   // untouched dividend for the divide-by-zero result
    logic               div_zero_reg;
    logic               div_reg;
    logic               signed_reg;
    logic               sign_a_reg;
    logic               sign_b_reg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_trial;

    // The most negative value maps onto itself, which reads correctly as an
    // unsigned magnitude of 2^(WIDTH-1).
    assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Carry out of the upper-half add lands in the top bit after the shift.
    assign acc_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
    assign rem_shift = {rem_reg, quot_reg[WIDTH-1]};
    assign rem_trial = rem_shift - {1'b0, opnd_reg};

    assign last = (count_reg == CW'(WIDTH - 1));

    // Operand latch on load, one multiply or divide step per cycle on step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg    <= '0;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            rem_reg      <= '0;
            quot_reg     <= '0;
            a_raw_reg    <= '0;
            div_zero_reg <= 1'b0;
            div_reg      <= 1'b0;
            signed_reg   <= 1'b0;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
        end else if (load) begin
            count_reg    <= '0;
            acc_reg      <= is_div ? '0 : {{WIDTH{1'b0}}, b_mag};
            opnd_reg     <= is_div ? b_mag : a_mag;
            rem_reg      <= '0;
            quot_reg     <= is_div ? a_mag : '0;
            a_raw_reg    <= a;
            div_zero_reg <= (b == '0);
            div_reg      <= is_div;
            signed_reg   <= is_signed;
            sign_a_reg   <= a[WIDTH-1];
            sign_b_reg   <= b[WIDTH-1];
        end else if (step) begin
            count_reg <= count_reg + CW'(1);
            if (div_reg) begin
                if (!rem_trial[WIDTH]) begin
                    rem_reg  <= rem_trial[WIDTH-1:0];
                    quot_reg <= {quot_reg[WIDTH-2:0], 1'b1};
                end else begin
                    rem_reg  <= rem_shift[WIDTH-1:0];
                    quot_reg <= {quot_reg[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (acc_reg[0]) begin
                    acc_reg <= {acc_sum, acc_reg[WIDTH-1:1]};
                end else begin
                    acc_reg <= {1'b0, acc_reg[2*WIDTH-1:1]};
                end
            end
        end
    end

    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Sign correction of the magnitude results, selected by op kind.
    always_comb begin
        neg_q    = signed_reg && (sign_a_reg != sign_b_reg);
        neg_r    = signed_reg && sign_a_reg;
        prod     = neg_q ? (~acc_reg + 1'b1) : acc_reg;
        quot_fix = neg_q ? (~quot_reg + 1'b1) : quot_reg;
        rem_fix  = neg_r ? (~rem_reg + 1'b1) : rem_reg;
        result_hi = prod[2*WIDTH-1:WIDTH];
        result_lo = prod[WIDTH-1:0];
        if (div_reg) begin
            if (div_zero_reg) begin
                result_hi = a_raw_reg;
                result_lo = '1;
            end else begin
                result_hi = rem_fix;
                result_lo = quot_fix;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// HI/LO owner for the single-cycle CPU: sequences iterative MULT/DIV ops,
// stalls the pipeline while they run, and handles MTHI/MTLO directly.
module hilo_muldiv_seq
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                clk,
    input logic                rst,
    hilo_muldiv_seq_if.slave   bus
);
    state_t state_reg;
    state_t state_next;

    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    logic             issue_ok;
    logic             load;
    logic             step;
    logic             fix;
    logic             write_hi;
    logic             write_lo;
    logic             last;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    // A held start during the done cycle belongs to the retiring instruction.
    assign issue_ok = (state_reg == ST_IDLE) && bus.start && !done_reg;

    muldiv_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .is_div    (bus.op[1]),
        .is_signed (!bus.op[0]),
        .a         (bus.a),
        .b         (bus.b),
        .last      (last),
        .result_hi (result_hi),
        .result_lo (result_lo)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath controls.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (issue_ok) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            load       = 1'b1;
                            state_next = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            load       = 1'b1;
                            state_next = ST_DIV;
                        end
                        OP_MTHI: write_hi = 1'b1;
                        OP_MTLO: write_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                step = 1'b1;
                if (last) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                fix        = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // HI/LO registers and the busy/done status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_reg   <= '0;
            lo_reg   <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= fix;
            if (load) begin
                busy_reg <= 1'b1;
            end else if (fix) begin
                busy_reg <= 1'b0;
            end
            if (fix) begin
                hi_reg <= result_hi;
                lo_reg <= result_lo;
            end else begin
                if (write_hi) begin
                    hi_reg <= bus.a;
                end
                if (write_lo) begin
                    lo_reg <= bus.a;
                end
            end
        end
    end

    assign bus.stall = rst && ((issue_ok && is_muldiv(bus.op)) || (state_reg != ST_IDLE));
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.hi    = hi_reg;
    assign bus.lo    = lo_reg;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed bench for hilo_muldiv_seq: hand-computed HI/LO results, stall
// length, done pulse, start-hold immunity, MTHI/MTLO and mid-op reset.
module tb_hilo_muldiv_seq;
    import hilo_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    hilo_muldiv_seq_if #(.WIDTH(W)) bus ();

    hilo_muldiv_seq #(
        .WIDTH(W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one mul/div op, hold start through the done cycle, then release.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int stalls = 0;
        int busys  = 0;
        bit finished = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        for (int i = 0; i < 100 && !finished; i++) begin
            #1;
            if (bus.done) begin
                finished = 1'b1;
            end else begin
                if (bus.stall) stalls++;
                if (bus.busy) busys++;
                @(negedge clk);
            end
        end
        check({tag, " done_seen"}, 64'(finished), 64'd1);
        check({tag, " stall_cycles"}, 64'(stalls), 64'(W + 2));
        check({tag, " busy_cycles"}, 64'(busys), 64'(W + 1));
        check({tag, " stall_in_done"}, 64'(bus.stall), 64'd0);
        check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
        $display("txn %s: op=%0d a=0x%08h b=0x%08h hi=0x%08h lo=0x%08h stalls=%0d",
                 tag, op, a, b, bus.hi, bus.lo, stalls);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check({tag, " no_retrigger_busy"}, 64'(bus.busy), 64'd0);
        check({tag, " done_one_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd5;
        bus.b     = 32'd3;
        repeat (3) @(negedge clk);
        #1;
        check("reset stall_forced_low", 64'(bus.stall), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        $display("txn reset: hi=0x%08h lo=0x%08h", bus.hi, bus.lo);
        bus.start = 1'b0;
        rst = 1'b1;

        run_op("mult_neg2x3",  OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_m7_by_2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_by_zero", OP_DIVU,  32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_overflow", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // MTHI then MTLO on consecutive cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = 32'h1234_5678;
        #1;
        check("mthi stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.op = OP_MTLO;
        bus.a  = 32'h9ABC_DEF0;
        #1;
        check("mtlo stall", 64'(bus.stall), 64'd0);
        check("mthi hi", 64'(bus.hi), 64'h1234_5678);
        $display("txn mthi: hi=0x%08h", bus.hi);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("mtlo lo", 64'(bus.lo), 64'h9ABC_DEF0);
        check("mtlo hi_kept", 64'(bus.hi), 64'h1234_5678);
        check("mt busy", 64'(bus.busy), 64'd0);
        check("mt done", 64'(bus.done), 64'd0);
        $display("txn mtlo: lo=0x%08h", bus.lo);

        // Reset in the middle of a DIVU.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        repeat (10) @(negedge clk);
        #1;
        check("midreset busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("midreset hi", 64'(bus.hi), 64'd0);
        check("midreset lo", 64'(bus.lo), 64'd0);
        check("midreset busy", 64'(bus.busy), 64'd0);
        check("midreset done", 64'(bus.done), 64'd0);
        check("midreset stall", 64'(bus.stall), 64'd0);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("after_reset idle_stall", 64'(bus.stall), 64'd0);
        check("after_reset busy", 64'(bus.busy), 64'd0);
        $display("txn midreset: hi=0x%08h lo=0x%08h", bus.hi, bus.lo);

        run_op("multu_6x7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
